// File: rtl/runway_allocator.sv
// runway_allocator: grants the lowest-index free runway, releases only for the
// owning plane, auto-releases stale locks by watchdog, supports emergency freeze.
module runway_allocator #(
    parameter int NUM_RUNWAYS = 2,
    parameter int ID_W        = 4,
    parameter int TIMEOUT     = 1024,
    localparam int IDX_W = (NUM_RUNWAYS > 1) ? $clog2(NUM_RUNWAYS) : 1,
    localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        lock_req,
    input  logic [ID_W-1:0]             lock_plane_id,
    input  logic                        unlock_req,
    input  logic [ID_W-1:0]             unlock_plane_id,
    input  logic [IDX_W-1:0]            unlock_runway,
    input  logic [NUM_RUNWAYS-1:0]      runway_busy_ext,
    input  logic                        emergency_set,
    input  logic                        emergency_clear,
    output logic                        lock_grant,
    output logic                        lock_deny,
    output logic [1:0]                  lock_deny_code,
    output logic [IDX_W-1:0]            lock_runway,
    output logic                        unlock_ok,
    output logic                        unlock_err,
    output logic [NUM_RUNWAYS-1:0]      timeout_flag,
    output logic [NUM_RUNWAYS-1:0]      runway_active,
    output logic [NUM_RUNWAYS*ID_W-1:0] runway_owner,
    output logic                        emergency
);

    localparam logic [1:0] DENY_FULL = 2'b01;
    localparam logic [1:0] DENY_DUP  = 2'b10;
    localparam logic [1:0] DENY_EMG  = 2'b11;

    localparam bit WD_EN = (TIMEOUT > 0);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WD_EN ? TIMEOUT - 1 : 0);
    localparam logic [TMR_W-1:0] TMR_MAX  = '1;

    typedef logic [NUM_RUNWAYS-1:0][ID_W-1:0]  owner_t;
    typedef logic [NUM_RUNWAYS-1:0][TMR_W-1:0] tmr_t;

    logic [NUM_RUNWAYS-1:0] active_q, active_d;
    owner_t                 owner_q, owner_d;
    tmr_t                   tmr_q, tmr_d;
    logic                   emergency_q, emergency_d;
    logic [NUM_RUNWAYS-1:0] timeout_q, timeout_d;
    logic                   grant_q, grant_d;
    logic                   deny_q, deny_d;
    logic [1:0]             code_q, code_d;
    logic [IDX_W-1:0]       rw_q, rw_d;
    logic                   uok_q, uok_d;
    logic                   uerr_q, uerr_d;

    logic [NUM_RUNWAYS-1:0] unlock_sel;
    logic [NUM_RUNWAYS-1:0] dup_hit;
    logic [NUM_RUNWAYS-1:0] cand;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_found;

    // Out-of-range unlock indices match no runway and fall through to an error.
    always_comb begin
        unlock_sel = '0;
        dup_hit    = '0;
        for (int i = 0; i < NUM_RUNWAYS; i++) begin
            unlock_sel[i] = active_q[i]
                && (unlock_runway == IDX_W'(i))
                && (owner_q[i] == unlock_plane_id);
            dup_hit[i] = active_q[i] && (owner_q[i] == lock_plane_id);
        end
        cand = ~active_q & ~runway_busy_ext;
    end

    always_comb begin
        pick_idx   = '0;
        pick_found = 1'b0;
        for (int i = 0; i < NUM_RUNWAYS; i++) begin
            if (cand[i] && !pick_found) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        active_d    = active_q;
        owner_d     = owner_q;
        tmr_d       = tmr_q;
        emergency_d = emergency_q;
        timeout_d   = '0;
        grant_d     = 1'b0;
        deny_d      = 1'b0;
        code_d      = '0;
        rw_d        = '0;
        uok_d       = 1'b0;
        uerr_d      = 1'b0;

        for (int i = 0; i < NUM_RUNWAYS; i++) begin
            if (WD_EN && active_q[i] && !emergency_q) begin
                if (tmr_q[i] == TMR_LAST) begin
                    active_d[i]  = 1'b0;
                    tmr_d[i]     = '0;
                    timeout_d[i] = 1'b1;
                end else if (tmr_q[i] != TMR_MAX) begin
                    tmr_d[i] = tmr_q[i] + TMR_W'(1);
                end
            end
        end

        // An accepted unlock overrides a watchdog expiry on the same runway.
        if (unlock_req) begin
            if (|unlock_sel) begin
                uok_d     = 1'b1;
                active_d  = active_d & ~unlock_sel;
                timeout_d = timeout_d & ~unlock_sel;
                for (int i = 0; i < NUM_RUNWAYS; i++) begin
                    if (unlock_sel[i]) begin
                        tmr_d[i] = '0;
                    end
                end
            end else begin
                uerr_d = 1'b1;
            end
        end

        if (lock_req) begin
            if (emergency_q) begin
                deny_d = 1'b1;
                code_d = DENY_EMG;
            end else if (|dup_hit) begin
                deny_d = 1'b1;
                code_d = DENY_DUP;
            end else if (!pick_found) begin
                deny_d = 1'b1;
                code_d = DENY_FULL;
            end else begin
                grant_d = 1'b1;
                rw_d    = pick_idx;
                for (int i = 0; i < NUM_RUNWAYS; i++) begin
                    if (pick_idx == IDX_W'(i)) begin
                        active_d[i] = 1'b1;
                        owner_d[i]  = lock_plane_id;
                        tmr_d[i]    = '0;
                    end
                end
            end
        end

        if (emergency_set) begin
            emergency_d = 1'b1;
        end else if (emergency_clear) begin
            emergency_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            active_q    <= '0;
            owner_q     <= '0;
            tmr_q       <= '0;
            emergency_q <= 1'b0;
            timeout_q   <= '0;
            grant_q     <= 1'b0;
            deny_q      <= 1'b0;
            code_q      <= '0;
            rw_q        <= '0;
            uok_q       <= 1'b0;
            uerr_q      <= 1'b0;
        end else begin
            active_q    <= active_d;
            owner_q     <= owner_d;
            tmr_q       <= tmr_d;
            emergency_q <= emergency_d;
            timeout_q   <= timeout_d;
            grant_q     <= grant_d;
            deny_q      <= deny_d;
            code_q      <= code_d;
            rw_q        <= rw_d;
            uok_q       <= uok_d;
            uerr_q      <= uerr_d;
        end
    end

    assign lock_grant     = grant_q;
    assign lock_deny      = deny_q;
    assign lock_deny_code = code_q;
    assign lock_runway    = rw_q;
    assign unlock_ok      = uok_q;
    assign unlock_err     = uerr_q;
    assign timeout_flag   = timeout_q;
    assign runway_active  = active_q;
    assign runway_owner   = owner_q;
    assign emergency      = emergency_q;

endmodule

// File: tb/tb_runway_allocator.sv
// Scoreboard bench for runway_allocator: a 4-runway/8-cycle-watchdog instance
// and a 3-runway/no-watchdog instance share stimulus against a reference model.
`timescale 1ns/1ps
module tb_runway_allocator;

    localparam int ID_W  = 4;
    localparam int IDX_W = 2;

    typedef struct packed {
        logic        grant;
        logic        deny;
        logic [1:0]  code;
        logic [3:0]  rw;
        logic        uok;
        logic        uerr;
        logic [15:0] flags;
        logic [15:0] act;
        logic [63:0] own;
        logic        emg;
    } exp_t;

    logic             clock = 1'b0;
    logic             reset_n = 1'b1;
    logic             lock_req = 1'b0;
    logic [ID_W-1:0]  lock_plane_id = '0;
    logic             unlock_req = 1'b0;
    logic [ID_W-1:0]  unlock_plane_id = '0;
    logic [IDX_W-1:0] unlock_runway = '0;
    logic [3:0]       busy = '0;
    logic             emergency_set = 1'b0;
    logic             emergency_clear = 1'b0;

    logic        a_grant, a_deny, a_uok, a_uerr, a_emg;
    logic [1:0]  a_code, a_rw;
    logic [3:0]  a_flag, a_act;
    logic [15:0] a_own;
    logic        b_grant, b_deny, b_uok, b_uerr, b_emg;
    logic [1:0]  b_code, b_rw;
    logic [2:0]  b_flag, b_act;
    logic [11:0] b_own;

    runway_allocator #(.NUM_RUNWAYS(4), .ID_W(ID_W), .TIMEOUT(8)) dut_a (
        .clock(clock), .reset_n(reset_n),
        .lock_req(lock_req), .lock_plane_id(lock_plane_id),
        .unlock_req(unlock_req), .unlock_plane_id(unlock_plane_id),
        .unlock_runway(unlock_runway), .runway_busy_ext(busy),
        .emergency_set(emergency_set), .emergency_clear(emergency_clear),
        .lock_grant(a_grant), .lock_deny(a_deny), .lock_deny_code(a_code),
        .lock_runway(a_rw), .unlock_ok(a_uok), .unlock_err(a_uerr),
        .timeout_flag(a_flag), .runway_active(a_act),
        .runway_owner(a_own), .emergency(a_emg)
    );

    runway_allocator #(.NUM_RUNWAYS(3), .ID_W(ID_W), .TIMEOUT(0)) dut_b (
        .clock(clock), .reset_n(reset_n),
        .lock_req(lock_req), .lock_plane_id(lock_plane_id),
        .unlock_req(unlock_req), .unlock_plane_id(unlock_plane_id),
        .unlock_runway(unlock_runway), .runway_busy_ext(busy[2:0]),
        .emergency_set(emergency_set), .emergency_clear(emergency_clear),
        .lock_grant(b_grant), .lock_deny(b_deny), .lock_deny_code(b_code),
        .lock_runway(b_rw), .unlock_ok(b_uok), .unlock_err(b_uerr),
        .timeout_flag(b_flag), .runway_active(b_act),
        .runway_owner(b_own), .emergency(b_emg)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_bad = 0;
    exp_t qa[$];
    exp_t qb[$];

    // Reference model state: index 0 mirrors dut_a, index 1 mirrors dut_b.
    bit mact[2][16];
    int mown[2][16];
    int mage[2][16];
    bit memg[2];

    function automatic int n_of(int m);
        return (m == 0) ? 4 : 3;
    endfunction

    function automatic int to_of(int m);
        return (m == 0) ? 8 : 0;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            memg[m] = 1'b0;
            for (int i = 0; i < 16; i++) begin
                mact[m][i] = 1'b0;
                mown[m][i] = 0;
                mage[m][i] = 0;
            end
        end
    endtask

    task automatic model_step(input int m, input bit lk, input int lid,
                              input bit ul, input int uid, input int urw,
                              input int bz, input bit es, input bit ec,
                              output exp_t e);
        int nn, to, hit;
        bit nact[16];
        int nage[16];
        int freel[$];
        nn = n_of(m);
        to = to_of(m);
        e = '0;
        for (int i = 0; i < nn; i++) begin
            nact[i] = mact[m][i];
            nage[i] = mage[m][i];
        end
        if (to > 0 && !memg[m]) begin
            for (int i = 0; i < nn; i++) begin
                if (mact[m][i]) begin
                    if (mage[m][i] == to - 1) begin
                        nact[i] = 1'b0;
                        nage[i] = 0;
                        e.flags[i] = 1'b1;
                    end else begin
                        nage[i] = mage[m][i] + 1;
                    end
                end
            end
        end
        if (ul) begin
            if (urw < nn && mact[m][urw] && mown[m][urw] == uid) begin
                nact[urw] = 1'b0;
                nage[urw] = 0;
                e.flags[urw] = 1'b0;
                e.uok = 1'b1;
            end else begin
                e.uerr = 1'b1;
            end
        end
        if (lk) begin
            hit = 0;
            for (int i = 0; i < nn; i++) begin
                if (mact[m][i] && mown[m][i] == lid) hit = 1;
                if (!mact[m][i] && !bz[i]) freel.push_back(i);
            end
            if (memg[m]) begin
                e.deny = 1'b1; e.code = 2'd3;
            end else if (hit != 0) begin
                e.deny = 1'b1; e.code = 2'd2;
            end else if (freel.size() == 0) begin
                e.deny = 1'b1; e.code = 2'd1;
            end else begin
                e.grant = 1'b1;
                e.rw = 4'(freel[0]);
                nact[freel[0]] = 1'b1;
                nage[freel[0]] = 0;
                mown[m][freel[0]] = lid;
            end
        end
        if (es) memg[m] = 1'b1;
        else if (ec) memg[m] = 1'b0;
        for (int i = 0; i < nn; i++) begin
            mact[m][i] = nact[i];
            mage[m][i] = nage[i];
            e.act[i] = nact[i];
            e.own[i*4 +: 4] = 4'(mown[m][i]);
        end
        e.emg = memg[m];
    endtask

    function automatic exp_t snap(int m);
        exp_t s;
        s = '0;
        if (m == 0) begin
            s.grant = a_grant; s.deny = a_deny; s.code = a_code;
            s.rw = 4'(a_rw); s.uok = a_uok; s.uerr = a_uerr;
            s.flags = 16'(a_flag); s.act = 16'(a_act);
            s.own = 64'(a_own); s.emg = a_emg;
        end else begin
            s.grant = b_grant; s.deny = b_deny; s.code = b_code;
            s.rw = 4'(b_rw); s.uok = b_uok; s.uerr = b_uerr;
            s.flags = 16'(b_flag); s.act = 16'(b_act);
            s.own = 64'(b_own); s.emg = b_emg;
        end
        return s;
    endfunction

    task automatic cmp(string nm, logic [63:0] g, logic [63:0] w);
        n_vec++;
        if (g !== w) begin
            n_bad++;
            $display("FAIL %s at %0t: got=%0h want=%0h", nm, $time, g, w);
        end
    endtask

    task automatic cmp_rec(string tag, exp_t g, exp_t e);
        cmp({tag, ".grant"}, 64'(g.grant), 64'(e.grant));
        cmp({tag, ".deny"},  64'(g.deny),  64'(e.deny));
        cmp({tag, ".code"},  64'(g.code),  64'(e.code));
        cmp({tag, ".rw"},    64'(g.rw),    64'(e.rw));
        cmp({tag, ".uok"},   64'(g.uok),   64'(e.uok));
        cmp({tag, ".uerr"},  64'(g.uerr),  64'(e.uerr));
        cmp({tag, ".flag"},  64'(g.flags), 64'(e.flags));
        cmp({tag, ".act"},   64'(g.act),   64'(e.act));
        cmp({tag, ".own"},   g.own,        e.own);
        cmp({tag, ".emg"},   64'(g.emg),   64'(e.emg));
    endtask

    always @(posedge clock) begin
        #1;
        if (qa.size() > 0) cmp_rec("A", snap(0), qa.pop_front());
        if (qb.size() > 0) cmp_rec("B", snap(1), qb.pop_front());
    end

    task automatic step(bit lk, int lid, bit ul, int uid, int urw,
                        int bz, bit es, bit ec);
        exp_t e;
        @(negedge clock);
        lock_req = lk;
        lock_plane_id = 4'(lid);
        unlock_req = ul;
        unlock_plane_id = 4'(uid);
        unlock_runway = 2'(urw);
        busy = 4'(bz);
        emergency_set = es;
        emergency_clear = ec;
        model_step(0, lk, lid, ul, uid, urw, bz, es, ec, e);
        qa.push_back(e);
        model_step(1, lk, lid, ul, uid, urw, bz, es, ec, e);
        qb.push_back(e);
    endtask

    task automatic idle(int n);
        repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic peek();
        @(posedge clock);
        #2;
    endtask

    task automatic mid_reset();
        @(negedge clock);
        lock_req = 1'b1;
        unlock_req = 1'b1;
        emergency_set = 1'b1;
        reset_n = 1'b0;
        #1;
        cmp_rec("rstA", snap(0), '0);
        cmp_rec("rstB", snap(1), '0);
        @(negedge clock);
        lock_req = 1'b0;
        unlock_req = 1'b0;
        emergency_set = 1'b0;
        emergency_clear = 1'b0;
        busy = '0;
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit lk, ul, es, ec;
        int lid, uid, urw, bz;
        model_reset();
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        cmp_rec("initA", snap(0), '0);
        cmp_rec("initB", snap(1), '0);
        @(negedge clock);
        reset_n = 1'b1;

        step(1, 5, 0, 0, 0, 0, 0, 0);
        peek();
        cmp("first_grant", 64'(a_grant), 1);
        cmp("first_rw", 64'(a_rw), 0);
        cmp("first_act", 64'(a_act), 64'h1);
        cmp("first_own0", 64'(a_own[3:0]), 5);

        step(0, 0, 1, 5, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 2, 0, 0, 0, 0, 0, 0);
        step(1, 3, 0, 0, 0, 0, 0, 0);
        step(1, 4, 0, 0, 0, 0, 0, 0);
        step(1, 6, 0, 0, 0, 0, 0, 0);
        peek();
        cmp("full_code", 64'(a_code), 1);
        cmp("full_act", 64'(a_act), 64'hf);

        step(0, 0, 1, 1, 0, 0, 0, 0);
        step(1, 6, 0, 0, 0, 1, 0, 0);
        peek();
        cmp("busy_code", 64'(a_code), 1);

        step(0, 0, 1, 7, 2, 0, 0, 0);
        peek();
        cmp("wrong_owner_err", 64'(a_uerr), 1);
        cmp("wrong_owner_act2", 64'(a_act[2]), 1);

        step(0, 0, 1, 3, 2, 0, 0, 0);
        peek();
        cmp("owner_ok", 64'(a_uok), 1);
        cmp("owner_act2", 64'(a_act[2]), 0);

        step(0, 0, 1, 5, 3, 0, 0, 0);
        peek();
        cmp("range_err_b", 64'(b_uerr), 1);

        idle(10);
        step(1, 5, 0, 0, 0, 0, 0, 0);
        step(1, 5, 1, 5, 0, 0, 0, 0);
        peek();
        cmp("dup_uok", 64'(a_uok), 1);
        cmp("dup_code", 64'(a_code), 2);
        step(1, 5, 0, 0, 0, 0, 0, 0);
        peek();
        cmp("regrant_rw", 64'(a_rw), 0);
        cmp("regrant", 64'(a_grant), 1);

        idle(10);
        step(1, 9, 0, 0, 0, 0, 0, 0);
        step(1, 10, 0, 0, 0, 0, 0, 0);
        idle(6);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        peek();
        cmp("wd_flag7", 64'(a_flag), 64'h1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        peek();
        cmp("wd_flag8", 64'(a_flag), 64'h2);
        cmp("wd_act1", 64'(a_act[1]), 0);

        step(1, 11, 0, 0, 0, 0, 0, 0);
        step(1, 12, 0, 0, 0, 0, 0, 0);
        idle(7);
        step(0, 0, 1, 12, 1, 0, 0, 0);
        peek();
        cmp("wd_race_uok", 64'(a_uok), 1);
        cmp("wd_race_flag", 64'(a_flag), 0);

        idle(2);
        step(1, 13, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        repeat (20) step(1, 14, 0, 0, 0, 0, 0, 0);
        peek();
        cmp("emg_code", 64'(a_code), 3);
        cmp("emg_frozen_act0", 64'(a_act[0]), 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 14, 0, 0, 0, 0, 0, 0);
        peek();
        cmp("post_emg_rw", 64'(a_rw), 1);

        mid_reset();

        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) mid_reset();
            lk = ($urandom_range(0, 9) < 4);
            lid = int'($urandom_range(0, 7));
            ul = ($urandom_range(0, 9) < 3);
            urw = int'($urandom_range(0, 3));
            uid = ($urandom_range(0, 1) == 1) ? mown[0][urw]
                                              : int'($urandom_range(0, 7));
            bz = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : 0;
            es = ($urandom_range(0, 49) == 0);
            ec = ($urandom_range(0, 14) == 0);
            step(lk, lid, ul, uid, urw, bz, es, ec);
        end

        idle(2);
        @(posedge clock);
        #3;
        cmp("drain_a", 64'(qa.size()), 0);
        cmp("drain_b", 64'(qb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
